sync_deserializer: RTL and testbench

SYNC_DESERIALIZER -- requirements
Module: sync_deserializer

---
 rtl/sync_deserializer.sv | 107 ++++++++++
 tb/tb_sync_deserializer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : sync_deserializer
// Brief    : Serial-to-parallel deserializer with sync-word alignment and a
//            one-deep valid/ready output register with overrun reporting.
// Revision : 1.0 - initial release
// ============================================================================
module sync_deserializer #(
  parameter int                 WIDTH     = 32,
  parameter logic [WIDTH-1:0]   SYNC_WORD = WIDTH'(32'hF0E1_D2C3)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             resync,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             locked,
  output logic             overrun
);

  localparam int FILL_W = $clog2(WIDTH + 1);
  localparam int BIT_W  = $clog2(WIDTH);

  localparam logic [0:0] c_st_hunt   = 1'b0;
  localparam logic [0:0] c_st_locked = 1'b1;

  localparam logic [FILL_W-1:0] c_fill_full = FILL_W'(WIDTH);
  localparam logic [FILL_W-1:0] c_fill_last = FILL_W'(WIDTH - 1);
  localparam logic [FILL_W-1:0] c_fill_one  = FILL_W'(1);
  localparam logic [BIT_W-1:0]  c_bit_last  = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0]  c_bit_one   = BIT_W'(1);

  logic [0:0]        r_state;
  logic [WIDTH-1:0]  r_shift;
  logic [FILL_W-1:0] r_fill;
  logic [BIT_W-1:0]  r_bit;
  logic [WIDTH-1:0]  r_dout;
  logic              r_valid;
  logic              r_overrun;

  logic [WIDTH-1:0]  w_next_shift;
  logic              w_sync_hit;
  logic              w_word_done;

  assign w_next_shift = {sin, r_shift[WIDTH-1:1]};

  // The fill threshold guarantees a full window of post-hunt bits before a match.
  assign w_sync_hit  = (r_state == c_st_hunt) && (r_fill >= c_fill_last) &&
                       (w_next_shift == SYNC_WORD);
  assign w_word_done = (r_state == c_st_locked) && (r_bit == c_bit_last) && !resync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_st_hunt;
      r_shift <= '0;
      r_fill  <= '0;
      r_bit   <= '0;
    end else begin
      r_shift <= w_next_shift;
      if (resync) begin
        r_state <= c_st_hunt;
        r_fill  <= '0;
        r_bit   <= '0;
      end else if (r_state == c_st_hunt) begin
        if (w_sync_hit) begin
          r_state <= c_st_locked;
          r_fill  <= '0;
          r_bit   <= '0;
        end else if (r_fill != c_fill_full) begin
          r_fill <= r_fill + c_fill_one;
        end
      end else begin
        r_bit <= (r_bit == c_bit_last) ? '0 : r_bit + c_bit_one;
      end
    end
  end

  // Output holding register: a completed word is dropped only if the previous one is stuck.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dout    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_word_done) begin
        if (!r_valid || dout_ready) begin
          r_dout  <= w_next_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && dout_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign locked     = (r_state == c_st_locked);
  assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sync_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_deserializer
// Brief    : Self-checking bench for sync_deserializer (WIDTH=8, sync 8'hD5).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_deserializer;

  logic       clk;
  logic       reset;
  logic       sin;
  logic       resync;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       locked;
  logic       overrun;

  sync_deserializer #(
    .WIDTH     (8),
    .SYNC_WORD (8'hD5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sin        (sin),
    .resync     (resync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .locked     (locked),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: bit history as a queue, alignment as plain counting.
  bit         q_bits[$];
  logic       m_locked;
  int         m_cnt;
  logic [7:0] m_dout;
  logic       m_valid;
  logic       m_ovr;
  logic [7:0] c_sync = 8'hD5;

  int          seq_err;
  int          ovr_seen;
  logic [10:0] last_obs;
  logic [10:0] last_exp;

  task automatic model_reset();
    q_bits.delete();
    m_locked = 1'b0;
    m_cnt    = 0;
    m_dout   = 8'h00;
    m_valid  = 1'b0;
    m_ovr    = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    sin = 1'b0; resync = 1'b0; dout_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Drive one serial bit, advance the model, and tally any per-cycle divergence.
  task automatic drive(input logic b, input logic rdy, input logic rs);
    logic [7:0] w;
    logic       done;
    sin = b; dout_ready = rdy; resync = rs;
    @(posedge clk);
    q_bits.push_back(b);
    if (q_bits.size() > 8) q_bits.delete(0);
    w = 8'h00;
    for (int i = 0; i < q_bits.size(); i++) w[8 - q_bits.size() + i] = q_bits[i];
    done  = 1'b0;
    m_ovr = 1'b0;
    if (rs) begin
      m_locked = 1'b0;
      m_cnt    = 0;
    end else if (!m_locked) begin
      if (m_cnt < 8) m_cnt++;
      if (m_cnt == 8 && w == c_sync) begin
        m_locked = 1'b1;
        m_cnt    = 0;
      end
    end else begin
      m_cnt++;
      if (m_cnt == 8) begin
        done  = 1'b1;
        m_cnt = 0;
      end
    end
    if (done) begin
      if (!m_valid || rdy) begin
        m_dout  = w;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    #1;
    if (overrun === 1'b1) ovr_seen++;
    if ({dout, dout_valid, locked, overrun} !== {m_dout, m_valid, m_locked, m_ovr}) begin
      seq_err++;
      last_obs = {dout, dout_valid, locked, overrun};
      last_exp = {m_dout, m_valid, m_locked, m_ovr};
    end
  endtask

  task automatic send_byte(input logic [7:0] w, input logic rdy, input logic rs_last);
    for (int i = 0; i < 8; i++) drive(w[i], rdy, (i == 7) ? rs_last : 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sin = 1'b0; resync = 1'b0; dout_ready = 1'b0;
    #12;
    n_chk++; if (dout !== 8'h00) $display("FAIL reset_dout: got %h want 00", dout); else n_pass++;
    n_chk++; if (dout_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", dout_valid); else n_pass++;
    n_chk++; if (locked !== 1'b0) $display("FAIL reset_locked: got %b want 0", locked); else n_pass++;
    n_chk++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else n_pass++;
  endtask

  task automatic test_lock_and_word();
    seq_err = 0;
    apply_reset();
    for (int i = 0; i < 3; i++) drive(1'($urandom_range(0, 1)), 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(c_sync[i], 1'b1, 1'b0);
      if (i == 6) begin
        n_chk++; if (locked !== 1'b0) $display("FAIL lock_early: got %b want 0", locked); else n_pass++;
      end
    end
    n_chk++; if (locked !== 1'b1) $display("FAIL lock_rise: got %b want 1", locked); else n_pass++;
    n_chk++; if (dout_valid !== 1'b0) $display("FAIL sync_not_delivered: valid %b want 0", dout_valid); else n_pass++;
    send_byte(8'h3C, 1'b1, 1'b0);
    n_chk++; if (dout !== 8'h3C || dout_valid !== 1'b1)
      $display("FAIL word_3c: got %h/%b want 3c/1", dout, dout_valid); else n_pass++;
    drive(1'b0, 1'b1, 1'b0);
    n_chk++; if (dout_valid !== 1'b0) $display("FAIL word_3c_consumed: valid %b want 0", dout_valid); else n_pass++;
    n_chk++; if (seq_err != 0) $display("FAIL lock_seq: %0d cycles off, last got %h want %h", seq_err, last_obs, last_exp); else n_pass++;
  endtask

  task automatic test_overrun();
    seq_err = 0; ovr_seen = 0;
    apply_reset();
    send_byte(c_sync, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0);
    n_chk++; if (dout !== 8'h11 || dout_valid !== 1'b1 || overrun !== 1'b0)
      $display("FAIL ovr_first: got %h/%b/%b want 11/1/0", dout, dout_valid, overrun); else n_pass++;
    send_byte(8'h22, 1'b0, 1'b0);
    n_chk++; if (overrun !== 1'b1 || dout !== 8'h11)
      $display("FAIL ovr_pulse: got ovr %b dout %h want 1/11", overrun, dout); else n_pass++;
    drive(1'b0, 1'b1, 1'b0);
    n_chk++; if (overrun !== 1'b0 || dout_valid !== 1'b0)
      $display("FAIL ovr_clear: got ovr %b valid %b want 0/0", overrun, dout_valid); else n_pass++;
    n_chk++; if (ovr_seen != 1) $display("FAIL ovr_count: got %0d want 1", ovr_seen); else n_pass++;
    n_chk++; if (seq_err != 0) $display("FAIL ovr_seq: %0d cycles off, last got %h want %h", seq_err, last_obs, last_exp); else n_pass++;
  endtask

  task automatic test_back_to_back();
    seq_err = 0; ovr_seen = 0;
    apply_reset();
    send_byte(c_sync, 1'b1, 1'b0);
    send_byte(8'hAA, 1'b1, 1'b0);
    n_chk++; if (dout !== 8'hAA || dout_valid !== 1'b1)
      $display("FAIL b2b_aa: got %h/%b want aa/1", dout, dout_valid); else n_pass++;
    send_byte(8'h55, 1'b1, 1'b0);
    n_chk++; if (dout !== 8'h55 || dout_valid !== 1'b1)
      $display("FAIL b2b_55: got %h/%b want 55/1", dout, dout_valid); else n_pass++;
    n_chk++; if (ovr_seen != 0) $display("FAIL b2b_overrun: got %0d pulses want 0", ovr_seen); else n_pass++;
    n_chk++; if (seq_err != 0) $display("FAIL b2b_seq: %0d cycles off, last got %h want %h", seq_err, last_obs, last_exp); else n_pass++;
  endtask

  task automatic test_no_early_lock();
    seq_err = 0;
    apply_reset();
    send_byte(c_sync, 1'b1, 1'b0);
    // Resync while shifting the first sync bit: the window matches after only 7 counted bits.
    drive(c_sync[0], 1'b1, 1'b1);
    for (int i = 1; i < 8; i++) drive(c_sync[i], 1'b1, 1'b0);
    n_chk++; if (locked !== 1'b0) $display("FAIL early_window: locked %b want 0", locked); else n_pass++;
    for (int i = 0; i < 7; i++) drive(c_sync[i], 1'b1, 1'b0);
    n_chk++; if (locked !== 1'b0) $display("FAIL partial_window: locked %b want 0", locked); else n_pass++;
    drive(c_sync[7], 1'b1, 1'b0);
    n_chk++; if (locked !== 1'b1) $display("FAIL full_window: locked %b want 1", locked); else n_pass++;
    n_chk++; if (seq_err != 0) $display("FAIL early_seq: %0d cycles off, last got %h want %h", seq_err, last_obs, last_exp); else n_pass++;
  endtask

  task automatic test_resync();
    seq_err = 0; ovr_seen = 0;
    apply_reset();
    send_byte(c_sync, 1'b1, 1'b0);
    send_byte(8'h5A, 1'b1, 1'b1);
    n_chk++; if (dout_valid !== 1'b0 || overrun !== 1'b0 || locked !== 1'b0)
      $display("FAIL resync_drop: got v%b o%b l%b want 0/0/0", dout_valid, overrun, locked); else n_pass++;
    send_byte(c_sync, 1'b1, 1'b0);
    n_chk++; if (locked !== 1'b1) $display("FAIL relock: locked %b want 1", locked); else n_pass++;
    send_byte(8'h96, 1'b1, 1'b0);
    n_chk++; if (dout !== 8'h96 || dout_valid !== 1'b1)
      $display("FAIL relock_word: got %h/%b want 96/1", dout, dout_valid); else n_pass++;
    n_chk++; if (seq_err != 0 || ovr_seen != 0)
      $display("FAIL resync_seq: %0d cycles off, ovr %0d, last got %h want %h", seq_err, ovr_seen, last_obs, last_exp); else n_pass++;
  endtask

  task automatic test_reset_async();
    seq_err = 0;
    apply_reset();
    send_byte(c_sync, 1'b0, 1'b0);
    send_byte(8'h77, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    n_chk++; if ({dout, dout_valid, locked, overrun} !== 11'h000)
      $display("FAIL async_reset: got %h/%b/%b/%b want all 0", dout, dout_valid, locked, overrun); else n_pass++;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    send_byte(8'h00, 1'b1, 1'b0);
    n_chk++; if (dout_valid !== 1'b0 || locked !== 1'b0)
      $display("FAIL post_reset_idle: got v%b l%b want 0/0", dout_valid, locked); else n_pass++;
    send_byte(c_sync, 1'b1, 1'b0);
    send_byte(8'hC4, 1'b1, 1'b0);
    n_chk++; if (dout !== 8'hC4 || dout_valid !== 1'b1)
      $display("FAIL post_reset_word: got %h/%b want c4/1", dout, dout_valid); else n_pass++;
    n_chk++; if (seq_err != 0) $display("FAIL async_seq: %0d cycles off, last got %h want %h", seq_err, last_obs, last_exp); else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] w;
    logic       rdy;
    seq_err = 0;
    apply_reset();
    rdy = 1'b1;
    for (int n = 0; n < 250; n++) begin
      w = ($urandom_range(0, 3) == 0) ? c_sync : 8'($urandom);
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 9) == 0) rdy = ~rdy;
        drive(w[i], rdy, ($urandom_range(0, 150) == 0) ? 1'b1 : 1'b0);
      end
    end
    n_chk++; if (seq_err != 0) $display("FAIL random_seq: %0d cycles off, last got %h want %h", seq_err, last_obs, last_exp); else n_pass++;
  endtask

  initial begin
    reset = 1'b1; sin = 1'b0; resync = 1'b0; dout_ready = 1'b0;
    seq_err = 0; ovr_seen = 0; last_obs = '0; last_exp = '0;
    model_reset();
    test_reset();
    test_lock_and_word();
    test_overrun();
    test_back_to_back();
    test_no_early_lock();
    test_resync();
    test_reset_async();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
